// File: rtl/pagerank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pagerank_pkg
//  Description : Shared types and constants for the PageRank scatter stream.
//                Holds the scatter FSM state encoding and the divider
//                latency definition.
//  Revision    : 1.0  initial release
// ============================================================================
package pagerank_pkg;

    // Scatter pass control states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIVIDE = 3'd1,
        EMIT   = 3'd2,
        NEXT   = 3'd3,
        DONE   = 3'd4
    } state_e;

    // A restoring divider retires one quotient bit per cycle, so its cycle
    // count equals the operand width.
    function automatic int div_cycles(input int data_w);
        return data_w;
    endfunction

    // Divider latency for the default 64-bit rank width
    localparam int DIV_CYCLES = div_cycles(64);

endpackage
`default_nettype wire

// File: rtl/pagerank_divider.sv
`default_nettype none
// ============================================================================
//  Module      : pagerank_divider
//  Description : Iterative restoring unsigned divider, one quotient bit per
//                cycle. The first step is taken on the edge that samples
//                start_i, so done_o rises div_cycles(DATA_W)-1 edges later
//                and the quotient is consumed DATA_W edges after launch.
//                done_o stays high until the next launch.
//  Ports       : clock_i, reset_i (async, active-high)
//                start_i        launch a division (divisor must be nonzero)
//                dividend_i     DATA_W-bit numerator
//                divisor_i      DATA_W-bit denominator
//                quotient_o     truncated quotient, valid while done_o=1
//                done_o         result ready
//  Revision    : 1.0  initial release
// ============================================================================
module pagerank_divider
    import pagerank_pkg::*;
#(
    parameter int DATA_W = DIV_CYCLES
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quotient_o,
    output logic              done_o
);

    localparam int STEPS = div_cycles(DATA_W);
    localparam int CW    = $clog2(STEPS + 1);

    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] divisor_q;
    logic [CW-1:0]     cnt_q;
    logic              done_q;

    logic [DATA_W-1:0] w_rem_src;
    logic [DATA_W-1:0] w_quo_src;
    logic [DATA_W-1:0] w_dvs;
    logic [DATA_W:0]   w_shift;
    logic              w_fits;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_rem_nxt;
    logic [DATA_W-1:0] w_quo_nxt;

    // On launch the step operates on fresh operands instead of the registers
    always_comb begin
        w_rem_src = start_i ? '0 : rem_q;
        w_quo_src = start_i ? dividend_i : quo_q;
        w_dvs     = start_i ? divisor_i : divisor_q;
        w_shift   = {w_rem_src, w_quo_src[DATA_W-1]};
        w_fits    = (w_shift >= {1'b0, w_dvs});
        // When the trial fits, the true difference is below 2^DATA_W
        w_diff    = w_shift[DATA_W-1:0] - w_dvs;
        w_rem_nxt = w_fits ? w_diff : w_shift[DATA_W-1:0];
        w_quo_nxt = {w_quo_src[DATA_W-2:0], w_fits};
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else if (start_i) begin
            rem_q     <= w_rem_nxt;
            quo_q     <= w_quo_nxt;
            divisor_q <= divisor_i;
            cnt_q     <= CW'(STEPS - 1);
            done_q    <= (STEPS == 1);
        end else if (cnt_q != '0) begin
            rem_q <= w_rem_nxt;
            quo_q <= w_quo_nxt;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                done_q <= 1'b1;
            end
        end
    end

    assign quotient_o = quo_q;
    assign done_o     = done_q;

endmodule
`default_nettype wire

// File: rtl/pagerank_scatter_stream.sv
`default_nettype none
// ============================================================================
//  Module      : pagerank_scatter_stream
//  Description : PageRank scatter engine. For each source vertex of a
//                partition, divides its snapshotted rank by its out-degree
//                and streams (contribution, destination) beats over a
//                valid/ready interface.
//  Ports       : clock_i, reset_i (async, active-high)
//                start_i, next_iteration_i    pass control
//                source_id_i, out_degree_i    per-source description
//                dest_id_i                    destination lists (MSB=1 ends)
//                page_rank_old_i              previous-iteration ranks
//                scatter_valid_o/ready_i/value_o/node_id_o   output stream
//                busy_o, operation_complete_o, edges_emitted_o,
//                iteration_count_o            status
//  Revision    : 1.0  initial release
// ============================================================================
module pagerank_scatter_stream
    import pagerank_pkg::*;
#(
    parameter int NODES_IN_PARTITION = 4,
    parameter int STREAM_SIZE        = 20,
    parameter int NODES_IN_GRAPH     = 32,
    parameter int DATA_W             = 64,
    parameter int ID_W               = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              next_iteration_i,
    input  logic [ID_W-1:0]   source_id_i     [NODES_IN_PARTITION],
    input  logic [ID_W-1:0]   out_degree_i    [NODES_IN_PARTITION],
    input  logic [ID_W-1:0]   dest_id_i       [NODES_IN_PARTITION][STREAM_SIZE],
    input  logic [DATA_W-1:0] page_rank_old_i [NODES_IN_GRAPH],
    output logic              scatter_valid_o,
    input  logic              scatter_ready_i,
    output logic [DATA_W-1:0] scatter_value_o,
    output logic [ID_W-1:0]   scatter_node_id_o,
    output logic              busy_o,
    output logic              operation_complete_o,
    output logic [ID_W-1:0]   edges_emitted_o,
    output logic [ID_W-1:0]   iteration_count_o
);

    localparam int PW = (NODES_IN_PARTITION > 1) ? $clog2(NODES_IN_PARTITION) : 1;
    localparam int SW = (STREAM_SIZE > 1) ? $clog2(STREAM_SIZE) : 1;
    localparam int IW = $clog2(NODES_IN_PARTITION + 1);
    localparam int JW = $clog2(STREAM_SIZE + 1);

    state_e            state_q;
    logic [IW-1:0]     i_q;
    logic [JW-1:0]     j_q;
    logic [DATA_W-1:0] rank_snap_q [NODES_IN_PARTITION];
    logic              launched_q;
    logic              scatter_valid_q;
    logic [DATA_W-1:0] scatter_value_q;
    logic [ID_W-1:0]   scatter_node_id_q;
    logic              busy_q;
    logic              complete_q;
    logic [ID_W-1:0]   edges_q;
    logic [ID_W-1:0]   iter_q;

    logic [DATA_W-1:0] rank_snap_d [NODES_IN_PARTITION];
    logic [PW-1:0]     w_src;
    logic [ID_W-1:0]   w_deg;
    logic              w_skip;
    logic [JW-1:0]     w_len;
    logic [JW-1:0]     w_j_next;
    logic [ID_W-1:0]   w_dest_cur;
    logic [ID_W-1:0]   w_dest_nxt;
    logic              w_more;
    logic              w_div_start;
    logic [DATA_W-1:0] w_quotient;
    logic              w_div_done;

    // Rank lookup by source id; out-of-range ids are skipped later anyway
    always_comb begin
        for (int k = 0; k < NODES_IN_PARTITION; k++) begin
            rank_snap_d[k] = '0;
            for (int g = 0; g < NODES_IN_GRAPH; g++) begin
                if (source_id_i[k] == ID_W'(g)) begin
                    rank_snap_d[k] = page_rank_old_i[g];
                end
            end
        end
    end

    // Narrow index; i_q only reaches NODES_IN_PARTITION outside DIVIDE/EMIT
    assign w_src      = i_q[PW-1:0];
    assign w_deg      = out_degree_i[w_src];
    assign w_skip     = (w_deg == '0) || (source_id_i[w_src] >= ID_W'(NODES_IN_GRAPH));
    assign w_j_next   = j_q + JW'(1);
    assign w_dest_cur = dest_id_i[w_src][j_q[SW-1:0]];
    // Entry j_next is only meaningful when it lies inside the effective list
    assign w_dest_nxt = dest_id_i[w_src][w_j_next[SW-1:0]];
    assign w_more     = (w_j_next < w_len) && !w_dest_nxt[ID_W-1];

    always_comb begin
        if (w_deg >= ID_W'(STREAM_SIZE)) begin
            w_len = JW'(STREAM_SIZE);
        end else begin
            w_len = w_deg[JW-1:0];
        end
    end

    assign w_div_start = (state_q == DIVIDE) && !w_skip && !launched_q;

    pagerank_divider #(
        .DATA_W (DATA_W)
    ) u_divider (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .start_i    (w_div_start),
        .dividend_i (rank_snap_q[w_src]),
        .divisor_i  (DATA_W'(w_deg)),
        .quotient_o (w_quotient),
        .done_o     (w_div_done)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q           <= IDLE;
            i_q               <= '0;
            j_q               <= '0;
            launched_q        <= 1'b0;
            scatter_valid_q   <= 1'b0;
            scatter_value_q   <= '0;
            scatter_node_id_q <= '0;
            busy_q            <= 1'b0;
            complete_q        <= 1'b0;
            edges_q           <= '0;
            iter_q            <= '0;
            for (int k = 0; k < NODES_IN_PARTITION; k++) begin
                rank_snap_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        rank_snap_q <= rank_snap_d;
                        i_q         <= '0;
                        j_q         <= '0;
                        edges_q     <= '0;
                        launched_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (w_skip) begin
                        state_q <= NEXT;
                    end else if (!launched_q) begin
                        launched_q <= 1'b1;
                    end else if (w_div_done) begin
                        launched_q <= 1'b0;
                        // A terminator in slot 0 means nothing to emit
                        if (!w_dest_cur[ID_W-1]) begin
                            scatter_valid_q   <= 1'b1;
                            scatter_value_q   <= w_quotient;
                            scatter_node_id_q <= w_dest_cur;
                            state_q           <= EMIT;
                        end else begin
                            state_q <= NEXT;
                        end
                    end
                end
                EMIT: begin
                    if (!scatter_valid_q) begin
                        state_q <= NEXT;
                    end else if (scatter_ready_i) begin
                        edges_q <= edges_q + ID_W'(1);
                        j_q     <= w_j_next;
                        if (w_more) begin
                            scatter_node_id_q <= w_dest_nxt;
                        end else begin
                            scatter_valid_q <= 1'b0;
                            state_q         <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    j_q <= '0;
                    i_q <= i_q + IW'(1);
                    if (i_q == IW'(NODES_IN_PARTITION - 1)) begin
                        busy_q     <= 1'b0;
                        complete_q <= 1'b1;
                        iter_q     <= iter_q + ID_W'(1);
                        state_q    <= DONE;
                    end else begin
                        state_q <= DIVIDE;
                    end
                end
                DONE: begin
                    if (next_iteration_i) begin
                        complete_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign scatter_valid_o      = scatter_valid_q;
    assign scatter_value_o      = scatter_value_q;
    assign scatter_node_id_o    = scatter_node_id_q;
    assign busy_o               = busy_q;
    assign operation_complete_o = complete_q;
    assign edges_emitted_o      = edges_q;
    assign iteration_count_o    = iter_q;

endmodule
`default_nettype wire

// File: tb/tb_pagerank_scatter_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pagerank_scatter_stream
//  Description : Self-checking bench for pagerank_scatter_stream with
//                DATA_W=16, two sources per partition, four slots per list.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pagerank_scatter_stream;

    localparam int NP = 2;
    localparam int SS = 4;
    localparam int NG = 32;
    localparam int DW = 16;
    localparam int IDW = 32;
    localparam logic [31:0] TERM = 32'h8000_0000;
    localparam int NVEC = 5;

    logic            clock;
    logic            reset;
    logic            start;
    logic            next_iteration;
    logic [IDW-1:0]  src_id [NP];
    logic [IDW-1:0]  deg    [NP];
    logic [IDW-1:0]  dst    [NP][SS];
    logic [DW-1:0]   ranks  [NG];
    logic            valid;
    logic            ready;
    logic [DW-1:0]   value;
    logic [IDW-1:0]  node;
    logic            busy;
    logic            complete;
    logic [IDW-1:0]  edges;
    logic [IDW-1:0]  iter;

    pagerank_scatter_stream #(
        .NODES_IN_PARTITION (NP),
        .STREAM_SIZE        (SS),
        .NODES_IN_GRAPH     (NG),
        .DATA_W             (DW),
        .ID_W               (IDW)
    ) dut (
        .clock_i              (clock),
        .reset_i              (reset),
        .start_i              (start),
        .next_iteration_i     (next_iteration),
        .source_id_i          (src_id),
        .out_degree_i         (deg),
        .dest_id_i            (dst),
        .page_rank_old_i      (ranks),
        .scatter_valid_o      (valid),
        .scatter_ready_i      (ready),
        .scatter_value_o      (value),
        .scatter_node_id_o    (node),
        .busy_o               (busy),
        .operation_complete_o (complete),
        .edges_emitted_o      (edges),
        .iteration_count_o    (iter)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [NP-1:0][31:0]         src;
        logic [NP-1:0][31:0]         dg;
        logic [NP-1:0][SS-1:0][31:0] ds;
        logic [NP-1:0][15:0]         rk;
        int                          nbeats;
        logic [7:0][15:0]            ev;
        logic [7:0][31:0]            en;
        int                          stall_beat;
        int                          stall_cyc;
        int                          lat;
    } vec_t;

    vec_t vecs [NVEC];
    int   checks;
    int   errors;
    int   exp_iter;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_src(input int v, input int k, input logic [31:0] s,
                           input logic [31:0] d, input logic [15:0] r,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3);
        vecs[v].src[k]   = s;
        vecs[v].dg[k]    = d;
        vecs[v].rk[k]    = r;
        vecs[v].ds[k][0] = a0;
        vecs[v].ds[k][1] = a1;
        vecs[v].ds[k][2] = a2;
        vecs[v].ds[k][3] = a3;
    endtask

    task automatic add_beat(input int v, input logic [15:0] val, input logic [31:0] nd);
        vecs[v].ev[vecs[v].nbeats] = val;
        vecs[v].en[vecs[v].nbeats] = nd;
        vecs[v].nbeats++;
    endtask

    task automatic init_vec(input int v, input int lat);
        vecs[v].nbeats     = 0;
        vecs[v].stall_beat = -1;
        vecs[v].stall_cyc  = 0;
        vecs[v].lat        = lat;
        vecs[v].ev         = '0;
        vecs[v].en         = '0;
    endtask

    task automatic load_inputs(input int v);
        for (int g = 0; g < NG; g++) ranks[g] = '0;
        for (int k = 0; k < NP; k++) begin
            src_id[k] = vecs[v].src[k];
            deg[k]    = vecs[v].dg[k];
            for (int s = 0; s < SS; s++) dst[k][s] = vecs[v].ds[k][s];
            if (vecs[v].src[k] < NG) ranks[vecs[v].src[k]] = vecs[v].rk[k];
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Runs one full pass; ends back in IDLE
    task automatic run_vector(input int v);
        int beats;
        int cyc;
        int stall_left;
        int first;
        beats      = 0;
        cyc        = 0;
        first      = -1;
        stall_left = vecs[v].stall_cyc;
        load_inputs(v);
        ready = 1'b1;
        pulse_start();
        // Ranks changed after the start edge must not leak into this pass
        for (int g = 0; g < NG; g++) ranks[g] = 16'hFFFF;
        chk($sformatf("v%0d busy_after_start", v), busy, 1);
        while (!complete && cyc < 2000) begin
            if (valid) begin
                if (first < 0) first = cyc;
                if (beats >= vecs[v].nbeats) begin
                    chk($sformatf("v%0d extra_beat", v), beats, vecs[v].nbeats);
                    ready = 1'b1;
                    beats++;
                end else if (beats == vecs[v].stall_beat && stall_left > 0) begin
                    ready = 1'b0;
                    stall_left--;
                    chk($sformatf("v%0d stall_value", v), value, vecs[v].ev[beats]);
                    chk($sformatf("v%0d stall_node", v), node, vecs[v].en[beats]);
                end else begin
                    ready = 1'b1;
                    chk($sformatf("v%0d beat%0d_value", v, beats), value, vecs[v].ev[beats]);
                    chk($sformatf("v%0d beat%0d_node", v, beats), node, vecs[v].en[beats]);
                    beats++;
                end
            end else begin
                ready = 1'b1;
            end
            @(negedge clock);
            cyc++;
        end
        ready = 1'b1;
        chk($sformatf("v%0d pass_timeout", v), (cyc < 2000), 1);
        exp_iter++;
        chk($sformatf("v%0d beat_count", v), beats, vecs[v].nbeats);
        if (vecs[v].lat > 0) chk($sformatf("v%0d first_valid_latency", v), first, vecs[v].lat);
        chk($sformatf("v%0d edges_emitted", v), edges, vecs[v].nbeats);
        chk($sformatf("v%0d iteration_count", v), iter, exp_iter);
        chk($sformatf("v%0d busy_in_done", v), busy, 0);
        chk($sformatf("v%0d valid_in_done", v), valid, 0);
        // start while DONE is ignored
        pulse_start();
        chk($sformatf("v%0d complete_held", v), complete, 1);
        chk($sformatf("v%0d busy_start_in_done", v), busy, 0);
        // release to IDLE with a simultaneous start that must be ignored
        @(negedge clock);
        next_iteration = 1'b1;
        start          = 1'b1;
        @(negedge clock);
        next_iteration = 1'b0;
        start          = 1'b0;
        chk($sformatf("v%0d complete_cleared", v), complete, 0);
        @(negedge clock);
        chk($sformatf("v%0d idle_not_busy", v), busy, 0);
    endtask

    initial begin
        int cyc;
        int seen;
        checks         = 0;
        errors         = 0;
        exp_iter       = 0;
        reset          = 1'b1;
        start          = 1'b0;
        next_iteration = 1'b0;
        ready          = 1'b1;
        for (int g = 0; g < NG; g++) ranks[g] = '0;
        for (int k = 0; k < NP; k++) begin
            src_id[k] = '0;
            deg[k]    = '0;
            for (int s = 0; s < SS; s++) dst[k][s] = '0;
        end

        // V0: rank 100 / 3 to {5,6,7}; source 1 has degree 0
        init_vec(0, 17);
        set_src(0, 0, 0, 3, 100, 5, 6, 7, TERM);
        set_src(0, 1, 1, 0, 50, 1, 1, 1, 1);
        add_beat(0, 33, 5); add_beat(0, 33, 6); add_beat(0, 33, 7);
        // V1: same, ready low for 5 cycles while beat 1 is offered
        init_vec(1, 17);
        set_src(1, 0, 0, 3, 100, 5, 6, 7, TERM);
        set_src(1, 1, 1, 0, 50, 1, 1, 1, 1);
        add_beat(1, 33, 5); add_beat(1, 33, 6); add_beat(1, 33, 7);
        vecs[1].stall_beat = 1;
        vecs[1].stall_cyc  = 5;
        // V2: terminator in slot 1; degree 9 truncated to 4 slots
        init_vec(2, 17);
        set_src(2, 0, 2, 4, 1000, 2, TERM, 3, 4);
        set_src(2, 1, 3, 9, 90, 10, 11, 12, 13);
        add_beat(2, 250, 2);
        add_beat(2, 10, 10); add_beat(2, 10, 11); add_beat(2, 10, 12); add_beat(2, 10, 13);
        // V3: source id out of graph range skipped; full-scale rank
        init_vec(3, 0);
        set_src(3, 0, 40, 2, 77, 1, 2, 3, 4);
        set_src(3, 1, 31, 2, 16'hFFFF, 8, 9, TERM, TERM);
        add_beat(3, 32767, 8); add_beat(3, 32767, 9);
        // V4: terminator in slot 0; quotient truncates to zero
        init_vec(4, 0);
        set_src(4, 0, 4, 1, 7, TERM, 1, 1, 1);
        set_src(4, 1, 5, 7, 5, 20, 21, 22, 23);
        add_beat(4, 0, 20); add_beat(4, 0, 21); add_beat(4, 0, 22); add_beat(4, 0, 23);

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_complete", complete, 0);
        chk("reset_edges", edges, 0);
        chk("reset_iter", iter, 0);
        chk("reset_value", value, 0);
        chk("reset_node", node, 0);

        for (int v = 0; v < NVEC; v++) run_vector(v);

        // Reset in the middle of EMIT abandons the pass
        load_inputs(0);
        ready = 1'b1;
        pulse_start();
        cyc = 0;
        while (!valid && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        chk("rst_reach_emit", valid, 1);
        @(negedge clock);
        chk("rst_edges_before", edges, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_edges", edges, 0);
        chk("rst_mid_iter", iter, 0);
        @(negedge clock);
        reset    = 1'b0;
        exp_iter = 0;
        seen     = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (valid || busy) seen++;
        end
        chk("rst_no_more_beats", seen, 0);
        run_vector(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
